// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
// Holds the control-state and Booth-digit encodings plus the digit-count helper.
package booth_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    typedef enum logic [2:0] {BD_ZERO, BD_POS1, BD_POS2, BD_NEG1, BD_NEG2} digit_t;

    // Operands are extended by two bits so both signed and unsigned fit one signed recoding.
    function automatic int ndig(input int width);
        return (width + 2) / 2;
    endfunction

    function automatic digit_t decodeDigit(input logic [2:0] triple);
        case (triple)
            3'b001, 3'b010: return BD_POS1;
            3'b011:         return BD_POS2;
            3'b100:         return BD_NEG2;
            3'b101, 3'b110: return BD_NEG1;
            default:        return BD_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_radix4_seq_mul_if.sv
// Request/result bundle for booth_radix4_seq_mul; Acc exists only when BOOTH_MAC_EN is defined.
// master = issue logic side, slave = multiplier side.
interface booth_radix4_seq_mul_if #(parameter int WIDTH = 32);
    logic               En;
    logic               Start;
    logic               Sign;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
`ifdef BOOTH_MAC_EN
    logic               Acc;
`endif
    logic               Busy;
    logic               Done;
    logic [2*WIDTH-1:0] Product;

    modport master (
        output En, Start, Sign, A, B,
`ifdef BOOTH_MAC_EN
        output Acc,
`endif
        input  Busy, Done, Product
    );

    modport slave (
        input  En, Start, Sign, A, B,
`ifdef BOOTH_MAC_EN
        input  Acc,
`endif
        output Busy, Done, Product
    );
endinterface

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial-product selector: picks 0/+-M/+-2M from a multiplier triple.
// Combinational; negative digits return ~M (or ~2M) with negCarry=1 for the shared adder.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int PW = 68
) (
    input  logic [2:0]    triple,
    input  logic [PW-1:0] mcand,
    output logic [PW-1:0] pp,
    output logic          negCarry
);

    digit_t digit;
    assign digit = decodeDigit(triple);

    always_comb begin
        pp       = '0;
        negCarry = 1'b0;
        case (digit)
            BD_POS1: pp = mcand;
            BD_POS2: pp = mcand << 1;
            BD_NEG1: begin
                pp       = ~mcand;
                negCarry = 1'b1;
            end
            BD_NEG2: begin
                pp       = ~(mcand << 1);
                negCarry = 1'b1;
            end
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_seq_mul.sv
// Iterative radix-4 Booth multiplier (signed/unsigned per op); optional MAC via BOOTH_MAC_EN.
// Latency: NDIG/DPC cycles from accepted Start to Done (17 for WIDTH=32, DPC=1).
// Backpressure: En=0 freezes everything including a pending Done; Start ignored while Busy.
module booth_radix4_seq_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DPC   = 1
) (
    input logic                   Clk,
    input logic                   Reset,
    booth_radix4_seq_mul_if.slave bus
);

    localparam int NDIG = ndig(WIDTH);
    localparam int NCYC = NDIG / DPC;
    localparam int PW   = 2 * WIDTH + 4;
    localparam int MW   = WIDTH + 3;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      mcandR;
    logic [MW-1:0]      mplierR;
    logic [PW-1:0]      accP;
    logic               busyR;
    logic               doneR;
    logic [2*WIDTH-1:0] productR;

    logic [WIDTH+1:0] extA;
    logic [WIDTH+1:0] extB;
    assign extA = {{2{bus.Sign & bus.A[WIDTH-1]}}, bus.A};
    assign extB = {{2{bus.Sign & bus.B[WIDTH-1]}}, bus.B};

    // DPC digits chained combinationally; each stage's carry-in realises the two's-complement negate.
    logic [DPC:0][PW-1:0] pSum;
    assign pSum[0] = accP;

    for (genvar j = 0; j < DPC; j++) begin : g_digit
        logic [PW-1:0] mcandJ;
        logic [PW-1:0] ppJ;
        logic          negJ;
        assign mcandJ = mcandR << (2 * j);
        booth_pp_gen #(.PW(PW)) u_pp (
            .triple   (mplierR[2*j+2:2*j]),
            .mcand    (mcandJ),
            .pp       (ppJ),
            .negCarry (negJ)
        );
        assign pSum[j+1] = pSum[j] + ppJ + {{(PW-1){1'b0}}, negJ};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mcandR   <= '0;
            mplierR  <= '0;
            accP     <= '0;
            busyR    <= 1'b0;
            doneR    <= 1'b0;
            productR <= '0;
        end else if (bus.En) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    doneR <= 1'b0;
                    if (bus.Start) begin
                        state   <= ST_RUN;
                        busyR   <= 1'b1;
                        cnt     <= '0;
                        mcandR  <= {{(PW-WIDTH-2){extA[WIDTH+1]}}, extA};
                        mplierR <= {extB, 1'b0};
`ifdef BOOTH_MAC_EN
                        accP    <= bus.Acc ? PW'(productR) : '0;
`else
                        accP    <= '0;
`endif
                    end else begin
                        state <= ST_IDLE;
                        busyR <= 1'b0;
                    end
                end
                ST_RUN: begin
                    accP    <= pSum[DPC];
                    mcandR  <= mcandR << (2 * DPC);
                    mplierR <= $signed(mplierR) >>> (2 * DPC);
                    if (cnt == CW'(NCYC - 1)) begin
                        state    <= ST_DONE;
                        busyR    <= 1'b0;
                        doneR    <= 1'b1;
                        productR <= pSum[DPC][2*WIDTH-1:0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busyR <= 1'b0;
                    doneR <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy    = busyR;
    assign bus.Done    = doneR;
    assign bus.Product = productR;

endmodule

// File: tb/tb_booth_radix4_seq_mul.sv
// Self-checking bench for booth_radix4_seq_mul (WIDTH=32): directed, random, stall, reset, back-to-back, MAC.
// Expected products come from plain 64-bit arithmetic on the sign- or zero-extended operands.
module tb_booth_radix4_seq_mul;

    localparam int WIDTH = 32;
    localparam int DPC   = 1;
    localparam int LAT   = ((WIDTH + 2) / 2) / DPC;

    logic Clk;
    logic Reset;
    int   passCnt  = 0;
    int   checkCnt = 0;

    booth_radix4_seq_mul_if #(.WIDTH(WIDTH)) bus ();

    booth_radix4_seq_mul #(.WIDTH(WIDTH), .DPC(DPC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [63:0] refMul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Issues one op and waits for Done; returns at the negedge where Done is first seen.
    task automatic runOp(input logic s, input logic [31:0] a, input logic [31:0] b, input logic acc,
                         input logic immediate, input int stallAt, input int stallLen, input int dupAt,
                         output int lat, output int busyCnt, output logic [63:0] prod, output logic ok);
        if (!immediate) @(negedge Clk);
        bus.Start = 1'b1;
        bus.Sign  = s;
        bus.A     = a;
        bus.B     = b;
`ifdef BOOTH_MAC_EN
        bus.Acc   = acc;
`else
        if (acc) $display("note: Acc requested without MAC build");
`endif
        @(posedge Clk);
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        lat = 0;
        busyCnt = 0;
        ok = 1'b0;
        while (!ok && lat < 300) begin
            if (bus.Done) begin
                ok = 1'b1;
            end else begin
                if (bus.Busy) busyCnt++;
                if (lat == stallAt) bus.En = 1'b0;
                if (lat == stallAt + stallLen) bus.En = 1'b1;
                if (lat == dupAt) begin
                    bus.Start = 1'b1;
                    bus.Sign  = ~s;
                    bus.A     = $urandom;
                    bus.B     = $urandom;
                end
                if (lat == dupAt + 1) bus.Start = 1'b0;
                @(negedge Clk);
                lat++;
            end
        end
        bus.En = 1'b1;
        prod = bus.Product;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.En = 1'b1;
        bus.Start = 1'b0;
        bus.Sign = 1'b0;
        bus.A = '0;
        bus.B = '0;
`ifdef BOOTH_MAC_EN
        bus.Acc = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        checkCnt++;
        if (bus.Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.Busy); else passCnt++;
        checkCnt++;
        if (bus.Done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.Done); else passCnt++;
        checkCnt++;
        if (bus.Product !== 64'h0) $display("FAIL reset_product got %h want 0", bus.Product); else passCnt++;
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_directed();
        logic        sv [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] av [5]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] bv [5]  = '{32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [63:0] pv [5]  = '{64'hFFFFFFFFFFFFFFEB, 64'hFFFFFFFE00000001, 64'h0000000000000001,
                                 64'h4000000000000000, 64'hC000000080000000};
        int lat, busyCnt;
        logic [63:0] prod;
        logic ok;
        for (int i = 0; i < 5; i++) begin
            runOp(sv[i], av[i], bv[i], 1'b0, 1'b0, -10, 0, -10, lat, busyCnt, prod, ok);
            checkCnt++;
            if (!ok || prod !== pv[i]) $display("FAIL directed_product[%0d] got %h want %h", i, prod, pv[i]); else passCnt++;
            checkCnt++;
            if (lat != LAT) $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, LAT); else passCnt++;
            checkCnt++;
            if (busyCnt != LAT) $display("FAIL directed_busy[%0d] got %0d want %0d", i, busyCnt, LAT); else passCnt++;
        end
    endtask

    task automatic test_random();
        int lat, busyCnt;
        logic [63:0] prod, exp;
        logic ok, s;
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) a = 32'h1 << $urandom_range(0, 31);
            exp = refMul(s, a, b);
            runOp(s, a, b, 1'b0, 1'b0, -10, 0, -10, lat, busyCnt, prod, ok);
            checkCnt++;
            if (!ok || prod !== exp) $display("FAIL random_product[%0d] s=%b a=%h b=%h got %h want %h", i, s, a, b, prod, exp); else passCnt++;
            @(negedge Clk);
            checkCnt++;
            if (bus.Done !== 1'b0) $display("FAIL random_done_pulse[%0d] got %b want 0", i, bus.Done); else passCnt++;
            repeat (2) @(negedge Clk);
            checkCnt++;
            if (bus.Product !== exp) $display("FAIL random_hold[%0d] got %h want %h", i, bus.Product, exp); else passCnt++;
        end
    endtask

    task automatic test_stall();
        int lat, busyCnt;
        logic [63:0] prod, exp;
        logic ok;
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        exp = refMul(1'b1, a, b);
        runOp(1'b1, a, b, 1'b0, 1'b0, 5, 5, 2, lat, busyCnt, prod, ok);
        checkCnt++;
        if (!ok || prod !== exp) $display("FAIL stall_product got %h want %h", prod, exp); else passCnt++;
        checkCnt++;
        if (lat != LAT + 5) $display("FAIL stall_latency got %0d want %0d", lat, LAT + 5); else passCnt++;
        bus.En = 1'b0;
        repeat (3) @(negedge Clk);
        checkCnt++;
        if (bus.Done !== 1'b1) $display("FAIL stall_done_stretch got %b want 1", bus.Done); else passCnt++;
        bus.En = 1'b1;
        @(negedge Clk);
        checkCnt++;
        if (bus.Done !== 1'b0) $display("FAIL stall_done_release got %b want 0", bus.Done); else passCnt++;
        checkCnt++;
        if (bus.Busy !== 1'b0) $display("FAIL stall_dup_start_busy got %b want 0", bus.Busy); else passCnt++;
    endtask

    task automatic test_reset_midrun();
        int lat, busyCnt;
        logic [63:0] prod, exp;
        logic ok;
        logic [31:0] a, b;
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Sign  = 1'b0;
        bus.A     = 32'h12345678;
        bus.B     = 32'h9ABCDEF0;
        @(posedge Clk);
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (7) @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkCnt++;
        if (bus.Busy !== 1'b0) $display("FAIL midrun_reset_busy got %b want 0", bus.Busy); else passCnt++;
        checkCnt++;
        if (bus.Done !== 1'b0) $display("FAIL midrun_reset_done got %b want 0", bus.Done); else passCnt++;
        checkCnt++;
        if (bus.Product !== 64'h0) $display("FAIL midrun_reset_product got %h want 0", bus.Product); else passCnt++;
        @(negedge Clk);
        Reset = 1'b1;
        a = $urandom;
        b = $urandom;
        exp = refMul(1'b1, a, b);
        runOp(1'b1, a, b, 1'b0, 1'b0, -10, 0, -10, lat, busyCnt, prod, ok);
        checkCnt++;
        if (!ok || prod !== exp) $display("FAIL midrun_restart_product got %h want %h", prod, exp); else passCnt++;
        checkCnt++;
        if (lat != LAT) $display("FAIL midrun_restart_latency got %0d want %0d", lat, LAT); else passCnt++;
    endtask

    task automatic test_back_to_back();
        int lat, busyCnt;
        logic [63:0] prod, exp;
        logic ok, s;
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        runOp(1'b0, a, b, 1'b0, 1'b0, -10, 0, -10, lat, busyCnt, prod, ok);
        for (int i = 0; i < 3; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            exp = refMul(s, a, b);
            runOp(s, a, b, 1'b0, 1'b1, -10, 0, -10, lat, busyCnt, prod, ok);
            checkCnt++;
            if (!ok || prod !== exp) $display("FAIL b2b_product[%0d] got %h want %h", i, prod, exp); else passCnt++;
            checkCnt++;
            if (lat != LAT || busyCnt != LAT) $display("FAIL b2b_timing[%0d] got lat=%0d busy=%0d want %0d", i, lat, busyCnt, LAT); else passCnt++;
        end
    endtask

`ifdef BOOTH_MAC_EN
    task automatic test_mac();
        int lat, busyCnt;
        logic [63:0] prod, exp;
        logic ok;
        logic [31:0] a, b;
        runOp(1'b0, 32'd5, 32'd6, 1'b0, 1'b0, -10, 0, -10, lat, busyCnt, prod, ok);
        checkCnt++;
        if (!ok || prod !== 64'd30) $display("FAIL mac_first got %h want 30", prod); else passCnt++;
        runOp(1'b0, 32'd2, 32'd3, 1'b1, 1'b0, -10, 0, -10, lat, busyCnt, prod, ok);
        checkCnt++;
        if (!ok || prod !== 64'd36) $display("FAIL mac_accum got %h want 36", prod); else passCnt++;
        a = $urandom;
        b = $urandom;
        exp = 64'd36 + refMul(1'b1, a, b);
        runOp(1'b1, a, b, 1'b1, 1'b0, -10, 0, -10, lat, busyCnt, prod, ok);
        checkCnt++;
        if (!ok || prod !== exp) $display("FAIL mac_signed got %h want %h", prod, exp); else passCnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_midrun();
        test_back_to_back();
`ifdef BOOTH_MAC_EN
        test_mac();
`endif
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
